// File: rtl/imem_loader_if.sv
// Byte-stream ingress and instruction-memory write port of the program loader.
// The loader takes the master side; the stream source / memory model takes the slave side.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: assembles little-endian words from a byte stream, writes them to
// instruction memory, verifies a trailing additive checksum and gates the core reset.
module imem_loader #(
  parameter int unsigned ADDR_W      = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  imem_loader_if.master     bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_W;
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_index;
  logic [CNT_W-1:0]  r_num_words;
  logic [1:0]        r_byte_cnt;
  logic [31:0]       r_word;
  logic [31:0]       r_csum;
  logic [31:0]       r_tmo;

  logic              r_byte_ready;
  logic              r_mem_we;
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_cpu_hold;

  logic              w_accept;
  logic              w_last_byte;
  logic              w_tmo_hit;
  logic              w_load_start;
  logic [31:0]       w_word_full;

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_load_start = 1'b0;
    w_accept     = bus.byte_valid & r_byte_ready;
    w_word_full  = {bus.byte_data, r_word[23:0]};
    w_last_byte  = w_accept && (r_byte_cnt == 2'd3);
    w_tmo_hit    = (TIMEOUT_CYC != 0) && !w_accept && (r_tmo == TMO_LAST);

    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          if (num_words == '0) begin
            w_state_nxt = ST_DONE;
          end else if (num_words > MAX_WORDS) begin
            w_state_nxt = ST_ERR;
          end else begin
            w_state_nxt  = ST_RECV;
            w_load_start = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (w_last_byte) begin
          w_state_nxt = ST_WRITE;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_ERR;
        end
      end
      ST_WRITE: begin
        if ((CNT_W'(r_index) + CNT_W'(1)) == r_num_words) begin
          w_state_nxt = ST_CSUM;
        end else begin
          w_state_nxt = ST_RECV;
        end
      end
      ST_CSUM: begin
        if (w_last_byte) begin
          w_state_nxt = (w_word_full == r_csum) ? ST_DONE : ST_ERR;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_ERR;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs, decoded from the upcoming state
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_index      <= '0;
      r_num_words  <= '0;
      r_byte_cnt   <= '0;
      r_word       <= '0;
      r_csum       <= '0;
      r_tmo        <= '0;
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cpu_hold   <= 1'b1;
    end else begin
      r_byte_ready <= (w_state_nxt == ST_RECV) || (w_state_nxt == ST_CSUM);
      r_mem_we     <= (w_state_nxt == ST_WRITE);
      r_busy       <= (w_state_nxt == ST_RECV) || (w_state_nxt == ST_WRITE) ||
                      (w_state_nxt == ST_CSUM);
      r_done       <= (w_state_nxt == ST_DONE);
      r_err        <= (w_state_nxt == ST_ERR);
      r_cpu_hold   <= (w_state_nxt != ST_DONE);

      if (w_load_start) begin
        r_index     <= '0;
        r_num_words <= num_words;
        r_byte_cnt  <= '0;
        r_csum      <= '0;
        r_tmo       <= '0;
      end else if (w_accept) begin
        r_word[{r_byte_cnt, 3'b000} +: 8] <= bus.byte_data;
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_tmo      <= '0;
        if (r_state == ST_RECV && w_last_byte) begin
          r_mem_addr  <= BASE_ADDR + (32'(r_index) << 2);
          r_mem_wdata <= w_word_full;
        end
      end else if (r_state == ST_RECV || r_state == ST_CSUM) begin
        r_tmo <= r_tmo + 32'd1;
      end

      if (r_state == ST_WRITE) begin
        r_csum  <= r_csum + r_mem_wdata;
        r_index <= r_index + ADDR_W'(1);
      end
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err            = r_err;
  assign cpu_hold       = r_cpu_hold;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; expected writes and status come
// from a word-list / checksum model built directly from the load format.
module tb_imem_loader;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned NW     = ADDR_W + 1;
  localparam int unsigned TMO    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [ADDR_W:0] num_words;
  logic          busy, done, err, cpu_hold;

  imem_loader_if bus ();

  imem_loader #(
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (32'h0000_0000),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .num_words(num_words),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] words[$];
  logic [64:0] wr_q[$];

  // Capture every memory write as {byte_ready, addr, data}
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) wr_q.push_back({bus.byte_ready, bus.mem_addr, bus.mem_wdata});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, advance to #1 after the next edge, report acceptance
  task automatic step(input bit v, input logic [7:0] d, input bit st, output bit acc);
    bit rdy;
    bus.byte_valid = v;
    bus.byte_data  = d;
    start          = st;
    rdy            = bus.byte_ready;
    @(posedge clk);
    #1;
    start = 1'b0;
    acc   = v && rdy;
  endtask

  task automatic rand_words(input int n);
    words = {};
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  // Full load of `words`; gap: 0 = always valid, 1 = toggle, 2 = random
  task automatic run_load(input bit bad, input int gap, input bit poke);
    logic [7:0]  bq[$];
    logic [31:0] sum;
    logic [64:0] e;
    bit          acc, v, poked;
    int          n, sent, cyc, gapc, budget;
    n   = words.size();
    sum = 32'd0;
    bq  = {};
    foreach (words[i]) begin
      sum += words[i];
      for (int b = 0; b < 4; b++) bq.push_back(words[i][8*b +: 8]);
    end
    if (bad) sum += 32'd1;
    for (int b = 0; b < 4; b++) bq.push_back(sum[8*b +: 8]);
    wr_q = {};
    num_words = NW'(n);
    step(1'b0, 8'h00, 1'b1, acc);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("ready_after_start", 32'(bus.byte_ready), 32'd1);
    chk("hold_during_load", 32'(cpu_hold), 32'd1);
    sent = 0; cyc = 0; gapc = 0; poked = 1'b0;
    budget = 20 * bq.size() + 50;
    while (sent < bq.size() && cyc < budget) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = ($urandom_range(0, 2) != 0) || (gapc >= 8);
      endcase
      if (poke && !poked && sent == 5) begin
        poked = 1'b1;
        num_words = '0;
        step(v, bq[sent], 1'b1, acc);
      end else begin
        step(v, bq[sent], 1'b0, acc);
      end
      cyc++;
      if (acc) begin
        sent++;
        gapc = 0;
        if (sent <= 4 * n && sent % 4 == 0) begin
          chk("we_after_4th", 32'(bus.mem_we), 32'd1);
          chk("we_addr", bus.mem_addr, 32'(4 * (sent / 4 - 1)));
          chk("we_data", bus.mem_wdata, words[sent / 4 - 1]);
          chk("ready_in_write", 32'(bus.byte_ready), 32'd0);
        end
      end else begin
        gapc++;
      end
    end
    bus.byte_valid = 1'b0;
    if (sent < bq.size()) chk("stream_budget", 32'(sent), 32'(bq.size()));
    chk("end_done", 32'(done), 32'(!bad));
    chk("end_err", 32'(err), 32'(bad));
    chk("end_hold", 32'(cpu_hold), 32'(bad));
    chk("end_busy", 32'(busy), 32'd0);
    chk("write_count", 32'(wr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      e = wr_q[i];
      chk("log_addr", e[63:32], 32'(4 * i));
      chk("log_data", e[31:0], words[i]);
      chk("log_ready_low", 32'(e[64]), 32'd0);
    end
  endtask

  initial begin
    bit acc;
    int sent, cyc, k;

    rst_n          = 1'b1;
    start          = 1'b1;
    num_words      = NW'(1);
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    rst_n = 1'b0;
    start = 1'b0;
    step(1'b0, 8'h00, 1'b0, acc);
    chk("rst_no_we", 32'(wr_q.size()), 32'd0);

    // Known program and checksum, then corrupted checksum
    words = '{32'h0050_0013, 32'h00A0_0093};
    run_load(1'b0, 0, 1'b0);
    words = '{32'h0050_0013, 32'h00A0_0093};
    run_load(1'b1, 0, 1'b0);

    // Gapped 3-word stream
    rand_words(3);
    run_load(1'b0, 1, 1'b0);

    // Random loads, some with a mid-load start pulse
    for (int t = 0; t < 6; t++) begin
      rand_words($urandom_range(1, 6));
      run_load(($urandom_range(0, 3) == 0), 2, t[0]);
    end

    // Full-depth load exercises the top address
    rand_words(256);
    run_load(1'b0, 0, 1'b0);

    // Stall timeout inside the first word
    wr_q = {};
    num_words = NW'(1);
    step(1'b0, 8'h00, 1'b1, acc);
    sent = 0; cyc = 0;
    while (sent < 3 && cyc < 20) begin
      step(1'b1, 8'(sent + 1), 1'b0, acc);
      cyc++;
      if (acc) sent++;
    end
    bus.byte_valid = 1'b0;
    chk("tmo_bytes_sent", 32'(sent), 32'd3);
    k = 1;
    while (k <= 40 && err !== 1'b1) begin
      step(1'b0, 8'h00, 1'b0, acc);
      k++;
    end
    chk("tmo_latency", 32'(k), 32'(TMO + 1));
    chk("tmo_hold", 32'(cpu_hold), 32'd1);
    chk("tmo_done", 32'(done), 32'd0);
    chk("tmo_no_we", 32'(wr_q.size()), 32'd0);

    // Reset after the 6th byte of a 2-word load
    rand_words(2);
    wr_q = {};
    num_words = NW'(2);
    step(1'b0, 8'h00, 1'b1, acc);
    sent = 0; cyc = 0;
    while (sent < 6 && cyc < 40) begin
      step(1'b1, words[sent / 4][8*(sent % 4) +: 8], 1'b0, acc);
      cyc++;
      if (acc) sent++;
    end
    rst_n = 1'b1;
    step(1'b1, 8'hAA, 1'b0, acc);
    rst_n = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(bus.byte_ready), 32'd0);
    chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
    for (int i = 0; i < 10; i++) step(1'b1, 8'h55, 1'b0, acc);
    bus.byte_valid = 1'b0;
    chk("mid_rst_writes", 32'(wr_q.size()), 32'd1);
    chk("mid_rst_idle", 32'(busy), 32'd0);

    // Count bounds
    num_words = NW'(257);
    step(1'b0, 8'h00, 1'b1, acc);
    chk("over_err", 32'(err), 32'd1);
    chk("over_busy", 32'(busy), 32'd0);
    chk("over_ready", 32'(bus.byte_ready), 32'd0);
    wr_q = {};
    num_words = NW'(0);
    step(1'b0, 8'h00, 1'b1, acc);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_hold", 32'(cpu_hold), 32'd0);
    chk("zero_err", 32'(err), 32'd0);
    step(1'b0, 8'h00, 1'b0, acc);
    chk("zero_no_we", 32'(wr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the instruction memory before the single-cycle core runs. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written to consecutive word-aligned addresses on the instruction-memory write port, and the load is closed with a 32-bit additive checksum. The block holds the core in reset (`cpu_hold`) until a load completes cleanly, so it is the writer for the memory the PC-driven fetch path reads.

## Interface
- `ADDR_W`, 8, word-address width; memory depth is 2^ADDR_W words.
- `BASE_ADDR`, 32'h0000_0000, byte address of the first written word; must be word aligned.
- `TIMEOUT_CYC`, 1024, maximum idle cycles between accepted bytes during a load; 0 disables the timeout.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst_n`  input  1  synchronous reset, active-high: sampled at the rising edge of `clk`, 1 = reset.
- `start`  input  1  one-cycle load request, sampled in IDLE, DONE or ERR.
- `num_words`  input  ADDR_W+1  word count, sampled with `start`.
- `byte_valid`  input  1  `byte_data` is valid.
- `byte_data`  input  8  stream byte.
- `byte_ready`  output  1  loader can accept a byte this cycle.
- `mem_we`  output  1  instruction-memory write strobe, one cycle per word.
- `mem_addr`  output  32  byte address of the write.
- `mem_wdata`  output  32  instruction word.
- `busy`  output  1  load in progress.
- `done`  output  1  last load completed with a matching checksum.
- `err`  output  1  last load failed.
- `cpu_hold`  output  1  keeps the core in reset while 1.

## Operation
- **States:** IDLE, RECV, WRITE, CSUM, DONE, ERR.
- **IDLE / DONE / ERR, `start`=1:**
  - `num_words`=0: go to DONE; no writes; checksum not expected.
  - `num_words` > 2^ADDR_W: go to ERR.
  - Otherwise: clear word index, byte counter, checksum accumulator and timeout counter, then go to RECV.
- **Other exits from IDLE / DONE / ERR:** none. `start` in RECV, WRITE or CSUM is ignored.
- **Byte transfer:** a byte is accepted when `byte_valid & byte_ready`. `byte_ready`=1 only in RECV and CSUM.
- **RECV:** byte k (0..3) of a word lands in bits [8k+7:8k]. When the 4th byte is accepted, go to WRITE.
- **WRITE** (exactly one cycle):
  - Outputs: `mem_we`=1, `mem_addr`=BASE_ADDR + 4*index, `mem_wdata`=assembled word.
  - The word is added into the checksum accumulator (mod 2^32) and the index increments.
  - Next state: CSUM if index+1 = `num_words`, else RECV.
- **CSUM:** accepts 4 bytes, little-endian, as the expected checksum. After the 4th byte, go to DONE on a match, else to ERR.
- **Timeout:** in RECV and CSUM, a counter clears on every accepted byte and otherwise increments. At `TIMEOUT_CYC` it forces ERR; a partial word is discarded and never written.
- **Flags:**
  - `busy`=1 in RECV/WRITE/CSUM.
  - `done`=1 only in DONE.
  - `err`=1 only in ERR.
  - `cpu_hold`=0 only in DONE; 1 in every other state.
- **ERR:** words already written stay in memory. Only `start` or reset leaves ERR.
- **Address width:** `mem_addr` upper bits are BASE_ADDR + (index << 2). Index never wraps because the count check bounds it.

## Timing
- **Reset values:** state IDLE; `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `err`=0, `cpu_hold`=1.
- **Reset mid-load:** abandons the load immediately and returns to the reset values on the next edge. Partial words are not written.
- **Start:** `start` at edge t gives `busy`=1 and `byte_ready`=1 in cycle t+1.
- **Throughput:** with `byte_valid` held 1, minimum 5 cycles per word (4 accepts + 1 WRITE). `byte_ready`=0 during WRITE.
- **Write timing:** `mem_we` is asserted in the cycle after the 4th byte of a word is accepted, and lasts exactly 1 cycle.
- **Completion:** `done`/`err` rise (and `cpu_hold` falls on success) the cycle after the last checksum byte is accepted. They hold until the next `start` or reset.
- **Timeout:** fires when the counter reaches `TIMEOUT_CYC`, i.e. `err`=1 `TIMEOUT_CYC`+1 cycles after the last accepted byte.
- **Inactive outputs:** `mem_addr`/`mem_wdata` hold their last values when `mem_we`=0.

## Test plan
- **Reset:** assert `rst_n`=1 for 2 cycles with `start`=1 → all outputs at their reset values, `cpu_hold`=1, no `mem_we`.
- **Clean 2-word load:** `num_words`=2, bytes 13 00 50 00 93 00 A0 00, checksum A6 00 F0 00 → write 0x00000000←0x00500013, then write 0x00000004←0x00A00093; `done`=1, `cpu_hold`=0, `err`=0.
- **Bad checksum:** same payload, checksum A7 00 F0 00 → both writes occur, then `err`=1, `cpu_hold`=1, `done`=0.
- **Stall timeout:** `TIMEOUT_CYC`=16, `num_words`=1, send 3 bytes then `byte_valid`=0 → `err`=1 17 cycles after the 3rd accept; no `mem_we` ever.
- **Gapped stream:** `byte_valid` toggling 1/0 every cycle over a 3-word load → data and addresses correct, `byte_ready`=0 in each WRITE cycle.
- **Ignored start / reset mid-load / bounds:**
  - `start` pulsed mid-load → ignored.
  - Reset after the 6th byte of a 2-word load → IDLE with no second write.
  - `num_words`=257 with `ADDR_W`=8 → ERR the cycle after `start`.
